csa19_resolver: RTL and testbench

- Multi-cycle carry-propagate stage directly downstream of the 19-bit half-adder carry-save stage.
- Takes its (cout, sum) vectors and resolves them into a single binary result for the Booth multiplier's final product.
- Adds CHUNK bits per cycle with a registered carry, so no full-width carry chain exists in one cycle.
- Uses a valid/ready handshake on both the input and the output side.

---
 rtl/csa19_resolver_pkg.sv | 23 ++
 rtl/csa19_resolver_cpa_chunk.sv | 29 ++
 rtl/csa19_resolver.sv | 155 +++++++++++++++
 tb/tb_csa19_resolver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/csa19_resolver_pkg.sv
// csa19_resolver_pkg
// Shared constants and types for the carry-propagate resolver that sits
// behind the 19-bit half-adder carry-save stage.
//   - default WIDTH / CHUNK shared with the carry-save stage
//   - FSM state encoding
//   - helper to derive the number of chunk-add cycles
package csa19_resolver_pkg;

  localparam int CSA_WIDTH_DEF = 19;
  localparam int CSA_CHUNK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit add cycles needed to cover a WIDTH+1 bit result.
  function automatic int calc_nchunk(input int width, input int chunk);
    return (width + 1 + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa19_resolver_cpa_chunk.sv
// cpa_chunk
// N-bit combinational ripple-carry adder used once per ADD cycle.
//   a, b : N-bit operands
//   cin  : carry in
//   s    : N-bit sum
//   cout : carry out
module cpa_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  // Bit-serial ripple through the chunk.
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/csa19_resolver.sv
// csa19_resolver
// Resolves the (cout, sum) vectors of the carry-save stage into one binary
// value, CHUNK bits per cycle with a registered carry.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   cout_in              : carry vector, bit i weighs 2^(i+1)
//   sum_in               : sum vector, bit i weighs 2^i
//   out_valid / out_ready: result handshake (held in DONE)
//   result               : (sum_in + (cout_in<<1)) mod 2^(WIDTH+1)
//   ovf                  : bit WIDTH+1 of the exact sum
//   busy                 : high in ADD or DONE
module csa19_resolver
  import csa19_resolver_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEF,
  parameter int CHUNK = CSA_CHUNK_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH-1:0] cout_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] result,
  output logic           ovf,
  output logic           busy
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [PW-1:0]   res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_cout_s;
  logic [PW-1:0]    res_shift_s;
  logic             pad_bit_s;

  cpa_chunk #(.N(CHUNK)) u_cpa_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // New chunk enters at the top; after NCHUNK shifts the result is LSB-aligned.
  assign res_shift_s = {chunk_sum_s, res_q[PW-1:CHUNK]};

  // With padding the overflow lands in bit WIDTH+1 rather than the final carry.
  if (PW > WIDTH + 1) begin : g_pad
    assign pad_bit_s = res_shift_s[WIDTH+1];
  end else begin : g_nopad
    assign pad_bit_s = 1'b0;
  end

  // Next-state and datapath control for the IDLE/ADD/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = PW'({1'b0, sum_in});
          b_d     = PW'({cout_in, 1'b0});
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_shift_s;
        carry_d = chunk_cout_s;
        if (cnt_q == CNT_LAST) begin
          ovf_d   = chunk_cout_s | pad_bit_s;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_ADD) || (state_d == ST_DONE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q[WIDTH:0];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa19_resolver.sv
// tb_csa19_resolver
// Directed-vector bench for csa19_resolver with hand-computed results.
module tb_csa19_resolver;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] cout_in;
  logic [18:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] result;
  logic        ovf;
  logic        busy;

  int checks;
  int failures;

  csa19_resolver dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cout_in   (cout_in),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair for one cycle in IDLE; returns just after the accept edge.
  task automatic start_op(input logic [18:0] s, input logic [18:0] c);
    sum_in   = s;
    cout_in  = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Hold off the consumer for `hold` cycles, then accept.
  task automatic finish_op(input int hold, input logic [19:0] exp_res, input logic exp_ovf);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_result", 32'(result), 32'(exp_res));
      chk("bp_ovf", 32'(ovf), 32'(exp_ovf));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [18:0] s, input logic [18:0] c,
                         input logic [19:0] exp_res, input logic exp_ovf, input int hold);
    int lat;
    start_op(s, c);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    finish_op(hold, exp_res, exp_ovf);
  endtask

  initial begin
    int lat;
    int stray;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = 19'h00000;
    cout_in   = 19'h00000;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // out_ready in IDLE has no effect.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_nop", 32'(out_valid), 32'd0);

    run_vec("basic",  19'h00005, 19'h00003, 20'h0000B, 1'b0, 0);
    run_vec("ripple", 19'h7FFFF, 19'h00001, 20'h80001, 1'b0, 0);
    run_vec("ovf",    19'h7FFFF, 19'h7FFFF, 20'h7FFFD, 1'b1, 3);
    run_vec("mixed",  19'h12345, 19'h54321, 20'hBA987, 1'b0, 1);

    // Reset during the third ADD cycle.
    start_op(19'h7FFFF, 19'h7FFFF);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    run_vec("post_rst", 19'h00010, 19'h00008, 20'h00020, 1'b0, 0);

    // New data offered during ADD must be ignored.
    start_op(19'h00005, 19'h00003);
    sum_in   = 19'h7FFFF;
    cout_in  = 19'h7FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    chk("ign_latency", 32'(lat), 32'd4);
    chk("ign_result", 32'(result), 32'h0000B);
    chk("ign_ovf", 32'(ovf), 32'd0);
    finish_op(0, 20'h0000B, 1'b0);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    chk("ign_no_extra_op", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
